// File: rtl/adc_threshold_detect_pkg.sv
// Shared Rhythm sequencer package: latch-point defaults, detector FSM
// encodings and small arithmetic helpers used by the threshold detector.
package adc_threshold_detect_pkg;

    // Sequencer position at which a finished ADC conversion is captured.
    localparam logic [31:0] MS_LATCH_DEFAULT      = 32'd100;
    localparam logic [5:0]  LATCH_CHANNEL_DEFAULT = 6'd23;

    // Detector states: two stable levels, each with a debounce pending state.
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } det_state_e;

    // Lower threshold = threshold - hysteresis, clamped to 0 on borrow.
    function automatic logic [15:0] low_threshold(input logic [15:0] thr,
                                                  input logic [15:0] hyst);
        logic [16:0] diff;
        diff = {1'b0, thr} - {1'b0, hyst};
        return diff[16] ? 16'd0 : diff[15:0];
    endfunction

    // Output level implied by a detector state.
    function automatic logic state_level(input det_state_e s);
        return (s == HIGH) || (s == FALL_PEND);
    endfunction

    // Increment that sticks at the counter maximum.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'd255) ? 8'd255 : (v + 8'd1);
    endfunction

endpackage

// File: rtl/adc_threshold_detect_if.sv
// Signal bundle between the sequencer/control side and the threshold detector.
interface adc_threshold_detect_if;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic [15:0] ADC_register;
    logic        enable;
    logic [15:0] threshold;
    logic [15:0] hysteresis;
    logic        polarity;
    logic [7:0]  debounce;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        digout;
    logic        edge_pulse;

    // Driver side: sequencer and control registers.
    modport master (
        output main_state, channel, ADC_register,
        output enable, threshold, hysteresis, polarity, debounce,
        input  sample_out, sample_valid, digout, edge_pulse
    );

    // Detector side.
    modport slave (
        input  main_state, channel, ADC_register,
        input  enable, threshold, hysteresis, polarity, debounce,
        output sample_out, sample_valid, digout, edge_pulse
    );
endinterface

// File: rtl/adc_threshold_detect.sv
// ADC threshold detector: captures the ADC result at the sequencer latch
// point, then runs a debounced hysteresis comparator on each captured sample.
// Comparator and FSM are deliberately kept in this single module.
module adc_threshold_detect
    import adc_threshold_detect_pkg::*;
#(
    parameter logic [31:0] ms_latch      = MS_LATCH_DEFAULT,
    parameter logic [5:0]  latch_channel = LATCH_CHANNEL_DEFAULT
) (
    input  logic                       dataclk,
    input  logic                       reset,
    adc_threshold_detect_if.slave      bus
);

    logic        latch_s;
    logic [15:0] sample_q;
    logic        valid_q;
    logic [15:0] lo_s;
    logic        rise_s;
    logic        fall_s;
    det_state_e  state_q;
    det_state_e  state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        level_q;
    logic        level_d;
    logic        edge_q;
    logic        edge_d;
    logic        digout_q;
    logic        digout_d;

    assign latch_s = (bus.main_state == ms_latch) && (bus.channel == latch_channel);

    // Capture the ADC result one cycle after the latch point; strobe valid.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            sample_q <= 16'd0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= latch_s;
            if (latch_s) begin
                sample_q <= bus.ADC_register;
            end else begin
                sample_q <= sample_q;
            end
        end
    end

    // Hysteresis comparators on the registered sample.
    always_comb begin
        lo_s   = low_threshold(bus.threshold, bus.hysteresis);
        rise_s = (sample_q >= bus.threshold);
        // With lo_s == 0 no unsigned sample can be below it.
        fall_s = (sample_q < lo_s);
    end

    // Next-state logic: evaluate only on valid samples, forced LOW when disabled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.enable) begin
            state_d = LOW;
            cnt_d   = 8'd0;
        end else if (valid_q) begin
            case (state_q)
                LOW: begin
                    if (rise_s) begin
                        if (bus.debounce == 8'd0) begin
                            state_d = HIGH;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = RISE_PEND;
                            cnt_d   = 8'd1;
                        end
                    end else begin
                        state_d = LOW;
                        cnt_d   = 8'd0;
                    end
                end
                RISE_PEND: begin
                    if (rise_s) begin
                        if (cnt_q == bus.debounce) begin
                            state_d = HIGH;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = RISE_PEND;
                            cnt_d   = sat_inc(cnt_q);
                        end
                    end else begin
                        state_d = LOW;
                        cnt_d   = 8'd0;
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        if (bus.debounce == 8'd0) begin
                            state_d = LOW;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = FALL_PEND;
                            cnt_d   = 8'd1;
                        end
                    end else begin
                        state_d = HIGH;
                        cnt_d   = 8'd0;
                    end
                end
                FALL_PEND: begin
                    if (fall_s) begin
                        if (cnt_q == bus.debounce) begin
                            state_d = LOW;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = FALL_PEND;
                            cnt_d   = sat_inc(cnt_q);
                        end
                    end else begin
                        state_d = HIGH;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = 8'd0;
                end
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // Output decode: a level change pulses only when the detector is enabled;
    // polarity alone just re-maps digout.
    always_comb begin
        level_d  = state_level(state_d);
        edge_d   = bus.enable && (level_d != level_q);
        digout_d = level_d ^ bus.polarity;
    end

    // Detector state, counter and registered outputs.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state_q  <= LOW;
            cnt_q    <= 8'd0;
            level_q  <= 1'b0;
            edge_q   <= 1'b0;
            digout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            edge_q   <= edge_d;
            digout_q <= digout_d;
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.digout       = digout_q;
    assign bus.edge_pulse   = edge_q;

endmodule

// File: tb/tb_adc_threshold_detect.sv
// Self-checking bench for adc_threshold_detect: directed scenarios plus a
// randomized run compared against a consecutive-count behavioural model.
module tb_adc_threshold_detect;

    logic dataclk;
    logic reset;
    int   checks;
    int   failures;

    adc_threshold_detect_if bus ();

    adc_threshold_detect dut (
        .dataclk (dataclk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial dataclk = 1'b0;
    always #5 dataclk = ~dataclk;

    // Behavioural model: registered sample/valid plus level and run length.
    bit          m_valid;
    logic [15:0] m_sample;
    bit          m_level;
    int          m_run;
    bit          exp_digout;
    bit          exp_edge;

    task automatic model_reset();
        m_valid    = 1'b0;
        m_sample   = 16'd0;
        m_level    = 1'b0;
        m_run      = 0;
        exp_digout = 1'b0;
        exp_edge   = 1'b0;
    endtask

    // Predict the effect of the coming rising edge from current inputs.
    task automatic model_step();
        int lo;
        bit q;
        bit nl;
        nl = m_level;
        if (!bus.enable) begin
            nl    = 1'b0;
            m_run = 0;
        end else if (m_valid) begin
            lo = int'(bus.threshold) - int'(bus.hysteresis);
            if (lo < 0) lo = 0;
            if (m_level) q = (int'(m_sample) < lo);
            else         q = (int'(m_sample) >= int'(bus.threshold));
            if (q) begin
                m_run = m_run + 1;
                if (m_run > int'(bus.debounce)) begin
                    nl    = !m_level;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        exp_edge   = bus.enable && (nl != m_level);
        exp_digout = nl ^ bus.polarity;
        m_level    = nl;
        m_valid    = (bus.main_state == 32'd100) && (bus.channel == 6'd23);
        if (m_valid) m_sample = bus.ADC_register;
    endtask

    task automatic tick();
        model_step();
        @(posedge dataclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge dataclk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_ctrl(input logic [15:0] thr, input logic [15:0] hy,
                            input logic [7:0] db, input logic pol);
        bus.threshold  = thr;
        bus.hysteresis = hy;
        bus.debounce   = db;
        bus.polarity   = pol;
        bus.enable     = 1'b1;
    endtask

    // Latch one sample and give the detector one cycle to evaluate it.
    task automatic feed(input logic [15:0] v);
        bus.main_state   = 32'd100;
        bus.channel      = 6'd23;
        bus.ADC_register = v;
        tick();
        bus.main_state   = 32'd0;
        bus.channel      = 6'd0;
        tick();
    endtask

    task automatic test_reset();
        bus.polarity = 1'b1;
        reset = 1'b1;
        model_reset();
        #2;
        checks++;
        if (bus.sample_out !== 16'd0 || bus.sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_sample: got %0d/%0b expected 0/0", bus.sample_out, bus.sample_valid);
        end
        checks++;
        if (bus.digout !== 1'b0 || bus.edge_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got digout=%0b edge=%0b expected 0/0", bus.digout, bus.edge_pulse);
        end
        @(posedge dataclk);
        #1;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.digout !== 1'b1) begin
            failures++;
            $display("FAIL reset_polarity_follow: got %0b expected 1", bus.digout);
        end
        bus.polarity = 1'b0;
        tick();
    endtask

    task automatic test_hysteresis();
        logic [15:0] smp [4] = '{16'd900, 16'd1000, 16'd950, 16'd899};
        bit          exd [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bit          exe [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        bit          prev;
        do_reset();
        set_ctrl(16'd1000, 16'd100, 8'd0, 1'b0);
        prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.main_state   = 32'd100;
            bus.channel      = 6'd23;
            bus.ADC_register = smp[k];
            tick();
            checks++;
            if (bus.sample_valid !== 1'b1 || bus.sample_out !== smp[k] || bus.digout !== prev) begin
                failures++;
                $display("FAIL hyst_latch[%0d]: got valid=%0b out=%0d digout=%0b expected 1/%0d/%0b",
                         k, bus.sample_valid, bus.sample_out, bus.digout, smp[k], prev);
            end
            bus.main_state = 32'd0;
            bus.channel    = 6'd0;
            tick();
            checks++;
            if (bus.sample_valid !== 1'b0 || bus.digout !== exd[k] || bus.edge_pulse !== exe[k]) begin
                failures++;
                $display("FAIL hyst_eval[%0d]: got valid=%0b digout=%0b edge=%0b expected 0/%0b/%0b",
                         k, bus.sample_valid, bus.digout, bus.edge_pulse, exd[k], exe[k]);
            end
            prev = exd[k];
        end
    endtask

    task automatic test_debounce();
        logic [15:0] smp [6] = '{16'd600, 16'd600, 16'd400, 16'd600, 16'd600, 16'd600};
        do_reset();
        set_ctrl(16'd500, 16'd0, 8'd2, 1'b0);
        for (int k = 0; k < 6; k++) begin
            feed(smp[k]);
            checks++;
            if (bus.digout !== (k == 5)) begin
                failures++;
                $display("FAIL debounce[%0d]: got %0b expected %0b", k, bus.digout, (k == 5));
            end
        end
    endtask

    task automatic test_lo_clamp();
        do_reset();
        set_ctrl(16'd50, 16'd100, 8'd0, 1'b0);
        feed(16'd60);
        feed(16'd0);
        checks++;
        if (bus.digout !== 1'b1 || bus.edge_pulse !== 1'b0) begin
            failures++;
            $display("FAIL lo_clamp: got digout=%0b edge=%0b expected 1/0", bus.digout, bus.edge_pulse);
        end
    endtask

    task automatic test_polarity_enable();
        do_reset();
        set_ctrl(16'd100, 16'd10, 8'd0, 1'b0);
        feed(16'd200);
        bus.polarity = 1'b1;
        tick();
        checks++;
        if (bus.digout !== 1'b0 || bus.edge_pulse !== 1'b0) begin
            failures++;
            $display("FAIL polarity_toggle: got digout=%0b edge=%0b expected 0/0", bus.digout, bus.edge_pulse);
        end
        bus.polarity = 1'b0;
        tick();
        bus.enable = 1'b0;
        tick();
        checks++;
        if (bus.digout !== 1'b0 || bus.edge_pulse !== 1'b0) begin
            failures++;
            $display("FAIL enable_off: got digout=%0b edge=%0b expected 0/0", bus.digout, bus.edge_pulse);
        end
        bus.enable = 1'b1;
        feed(16'd200);
        checks++;
        if (bus.digout !== 1'b1 || bus.edge_pulse !== 1'b1) begin
            failures++;
            $display("FAIL enable_restart: got digout=%0b edge=%0b expected 1/1", bus.digout, bus.edge_pulse);
        end
    endtask

    task automatic test_reset_mid_pending();
        do_reset();
        set_ctrl(16'd500, 16'd0, 8'd3, 1'b0);
        feed(16'd600);
        feed(16'd600);
        reset = 1'b1;
        model_reset();
        #2;
        checks++;
        if (bus.digout !== 1'b0 || bus.edge_pulse !== 1'b0 ||
            bus.sample_out !== 16'd0 || bus.sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL midpend_reset: got digout=%0b edge=%0b out=%0d valid=%0b expected all 0",
                     bus.digout, bus.edge_pulse, bus.sample_out, bus.sample_valid);
        end
        @(posedge dataclk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            feed(16'd600);
            checks++;
            if (bus.digout !== (k == 3)) begin
                failures++;
                $display("FAIL midpend_rise[%0d]: got %0b expected %0b", k, bus.digout, (k == 3));
            end
        end
    endtask

    task automatic test_channel_mismatch();
        do_reset();
        set_ctrl(16'd1000, 16'd0, 8'd0, 1'b0);
        feed(16'd777);
        bus.main_state   = 32'd100;
        bus.channel      = 6'd5;
        bus.ADC_register = 16'd123;
        tick();
        checks++;
        if (bus.sample_valid !== 1'b0 || bus.sample_out !== 16'd777) begin
            failures++;
            $display("FAIL chan_mismatch: got valid=%0b out=%0d expected 0/777", bus.sample_valid, bus.sample_out);
        end
        bus.main_state = 32'd0;
        bus.channel    = 6'd0;
    endtask

    task automatic test_random();
        int v;
        do_reset();
        set_ctrl(16'd1000, 16'd50, 8'd0, 1'b0);
        for (int blk = 0; blk < 8; blk++) begin
            // Debounce only changes while disabled, so no count is left pending.
            bus.enable     = 1'b0;
            bus.main_state = 32'd0;
            tick();
            bus.enable     = 1'b1;
            bus.debounce   = 8'($urandom_range(0, 3));
            bus.threshold  = 16'($urandom_range(200, 60000));
            bus.hysteresis = 16'($urandom_range(0, 400));
            bus.polarity   = 1'($urandom_range(0, 1));
            for (int i = 0; i < 100; i++) begin
                bus.main_state = 32'($urandom_range(99, 101));
                bus.channel    = 6'($urandom_range(22, 24));
                v = int'(bus.threshold) + $urandom_range(0, 600) - 300;
                if (v < 0) v = 0;
                if (v > 65535) v = 65535;
                bus.ADC_register = 16'(v);
                if ($urandom_range(0, 29) == 0) bus.polarity = ~bus.polarity;
                if ($urandom_range(0, 39) == 0) bus.hysteresis = 16'($urandom_range(0, 70000) % 65536);
                bus.enable = ($urandom_range(0, 49) != 0);
                tick();
                checks++;
                if (bus.sample_valid !== m_valid || bus.sample_out !== m_sample) begin
                    failures++;
                    $display("FAIL rnd_sample blk%0d cyc%0d: got %0b/%0d expected %0b/%0d",
                             blk, i, bus.sample_valid, bus.sample_out, m_valid, m_sample);
                end
                checks++;
                if (bus.digout !== exp_digout || bus.edge_pulse !== exp_edge) begin
                    failures++;
                    $display("FAIL rnd_detect blk%0d cyc%0d: got digout=%0b edge=%0b expected %0b/%0b",
                             blk, i, bus.digout, bus.edge_pulse, exp_digout, exp_edge);
                end
            end
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.main_state   = 32'd0;
        bus.channel      = 6'd0;
        bus.ADC_register = 16'd0;
        bus.enable       = 1'b1;
        bus.threshold    = 16'd1000;
        bus.hysteresis   = 16'd0;
        bus.polarity     = 1'b0;
        bus.debounce     = 8'd0;
        model_reset();
        test_reset();
        test_hysteresis();
        test_debounce();
        test_lo_clamp();
        test_polarity_enable();
        test_reset_mid_pending();
        test_channel_mismatch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_threshold_detect.md
ADC_THRESHOLD_DETECT -- requirements
Module: adc_threshold_detect

Interface
REQ-001 SHALL have parameter ms_latch, default 100: main_state value on which a completed conversion is latched.
REQ-002 SHALL have parameter latch_channel, default 23: channel value, together with ms_latch, that marks the latch point.
REQ-003 SHALL have port dataclk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports main_state input 32, channel input 6, and ADC_register input 16: sequencer state, sequencer slot, and unsigned ADC result from the upstream SPI stage.
REQ-006 SHALL have ports enable input 1, threshold input 16, hysteresis input 16, and polarity input 1: detector controls (unsigned; polarity=1 inverts digout).
REQ-007 SHALL have port debounce, input, 8: count of extra consecutive qualifying samples required before a transition.
REQ-008 SHALL have ports sample_out output 16 and sample_valid output 1: the latched sample and a 1-cycle strobe.
REQ-009 SHALL have ports digout output 1 and edge_pulse output 1: the thresholded level, and a 1-cycle strobe on each digout change.

Function
REQ-010 SHALL latch ADC_register into sample_out and assert sample_valid for exactly one cycle on the cycle after main_state==ms_latch && channel==latch_channel; sample_valid is 0 otherwise.
REQ-011 SHALL evaluate the detector only on cycles where the registered sample is valid; the state is held on all other cycles.
REQ-012 SHALL use FSM states LOW, RISE_PEND, HIGH, and FALL_PEND, plus an 8-bit counter cnt.
REQ-013 SHALL compute rise_q = (sample >= threshold).
REQ-014 SHALL compute fall_q = (sample < lo), where lo = threshold - hysteresis saturated at 0 (17-bit subtract, clamp on borrow); when lo=0, fall_q is never true.
REQ-015 SHALL transition from LOW on rise_q: to HIGH if debounce==0, else to RISE_PEND with cnt=1; with no rise_q, stay in LOW.
REQ-016 SHALL handle RISE_PEND as follows: on rise_q, if cnt==debounce go to HIGH, else cnt+1; on no rise_q, return to LOW with cnt=0.
REQ-017 SHALL mirror REQ-015 and REQ-016 from HIGH and FALL_PEND using fall_q, returning to LOW or HIGH respectively.
REQ-018 SHALL set level=1 in HIGH and FALL_PEND and level=0 otherwise; digout = level XOR polarity, registered.
REQ-019 SHALL assert edge_pulse for one cycle, in the same cycle digout changes, when level changes; a polarity change alone SHALL change digout without edge_pulse.
REQ-020 SHALL, while enable=0, force the FSM to LOW and cnt to 0 with no edge_pulse, while still latching samples per REQ-010.
REQ-021 SHALL saturate cnt at 255; debounce=255 is still reachable.
REQ-022 SHALL give threshold, hysteresis, or debounce changes effect at the next valid sample; in-progress pending counts are not reset.
REQ-023 SHALL make latency from the latch condition to a digout change 2 cycles when debounce==0.

Reset
REQ-024 SHALL, on reset assertion, asynchronously force sample_out=0, sample_valid=0, FSM=LOW, cnt=0, level=0, edge_pulse=0, and digout=polarity-independent 0.
REQ-025 SHALL apply reset asserted mid-pending by discarding the partial count; the first valid sample after release is evaluated from LOW.
REQ-026 SHALL, after reset, have digout follow polarity from the first clock edge.

Structure
REQ-027 SHALL place FSM state encodings and the default ms_latch and latch_channel constants in the shared Rhythm sequencer package.
REQ-028 SHALL use no sub-module; comparator and FSM are kept in one module.

Verification
REQ-029 SHALL cover: threshold=1000, hyst=100, debounce=0; samples 900, 1000, 950, 899 -> digout 0, 1, 1, 0, with edge_pulse on the 1000 and 899 samples only.
REQ-030 SHALL cover: debounce=2, threshold=500; samples 600, 600, 400, 600, 600, 600 -> digout rises only after the 6th sample.
REQ-031 SHALL cover: threshold=50, hyst=100 (lo clamps to 0); samples 60, 0 -> digout stays 1.
REQ-032 SHALL cover: polarity toggled while level=1 -> digout goes 1 to 0 with no edge_pulse; enable=0 -> level=0 with no pulse.
REQ-033 SHALL cover: reset asserted between samples 2 and 3 of a debounce=3 rise -> all outputs 0 immediately; post-release, 3 more qualifying samples plus the first are needed.
REQ-034 SHALL cover: a latch condition with main_state==ms_latch but channel!=latch_channel -> no sample_valid and sample_out unchanged.
